// File: rtl/bridge_uart_sequencer.sv
// Serializes 25-bit bus-bridge frames into four UART bytes under ready/valid.
// For reads it also waits (bounded by a timeout) for one response byte and returns it to the bridge.
module bridge_uart_sequencer #(
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH+10:0]  frame_in,
    input  logic                    frame_valid,
    output logic                    frame_busy,
    output logic [DATA_WIDTH-1:0]   rd_data_out,
    output logic                    rd_valid_out,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_valid,
    output logic                    timeout_err,
    output logic                    overrun_err
);

    localparam int FW = ADDR_WIDTH + 11;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, RESP} state_e;

    state_e                  state_q, state_d;
    logic [31:0]             shift_q, shift_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    rw_q, rw_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    tmo_err_q, tmo_err_d;
    logic                    ovr_q, ovr_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        tmo_d      = tmo_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        tmo_err_d  = 1'b0;
        ovr_d      = frame_valid && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (frame_valid) begin
                    // Read frames carry no payload, so B3 is forced to zero at latch time.
                    shift_d = {7'b0, frame_in[FW-1:DATA_WIDTH],
                               frame_in[FW-1] ? frame_in[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}}};
                    rw_d    = frame_in[FW-1];
                    cnt_d   = 2'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    shift_d = {shift_q[23:0], 8'h00};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (rw_q) begin
                            state_d = IDLE;
                        end else begin
                            tmo_d   = '0;
                            state_d = WAIT_RX;
                        end
                    end
                end
            end
            WAIT_RX: begin
                // A byte arriving on the terminal count takes priority over the timeout.
                if (rx_valid) begin
                    rd_data_d  = rx_data;
                    rd_valid_d = 1'b1;
                    state_d    = RESP;
                end else if (tmo_q == TMO_LAST) begin
                    rd_data_d  = '1;
                    rd_valid_d = 1'b1;
                    tmo_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        tx_valid_d = (state_d == SEND);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            tmo_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            tmo_err_q  <= 1'b0;
            ovr_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            tmo_q      <= tmo_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            tmo_err_q  <= tmo_err_d;
            ovr_q      <= ovr_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign frame_busy   = busy_q;
    assign rd_data_out  = rd_data_q;
    assign rd_valid_out = rd_valid_q;
    assign tx_data      = shift_q[31:24];
    assign tx_valid     = tx_valid_q;
    assign timeout_err  = tmo_err_q;
    assign overrun_err  = ovr_q;

endmodule

// File: tb/tb_bridge_uart_sequencer.sv
// Directed bench for bridge_uart_sequencer with hand-computed byte streams and response timing.
module tb_bridge_uart_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] frame_in;
    logic        frame_valid;
    logic        frame_busy;
    logic [7:0]  rd_data_out;
    logic        rd_valid_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        timeout_err;
    logic        overrun_err;

    int checks = 0;
    int errors = 0;

    bridge_uart_sequencer #(
        .ADDR_WIDTH(14),
        .DATA_WIDTH(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_in(frame_in),
        .frame_valid(frame_valid),
        .frame_busy(frame_busy),
        .rd_data_out(rd_data_out),
        .rd_valid_out(rd_valid_out),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .timeout_err(timeout_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {7'b0, frame_busy}, 8'h00);
        chk({tag, "_rdd"}, rd_data_out, 8'h00);
        chk({tag, "_rdv"}, {7'b0, rd_valid_out}, 8'h00);
        chk({tag, "_txd"}, tx_data, 8'h00);
        chk({tag, "_txv"}, {7'b0, tx_valid}, 8'h00);
        chk({tag, "_tmo"}, {7'b0, timeout_err}, 8'h00);
        chk({tag, "_ovr"}, {7'b0, overrun_err}, 8'h00);
    endtask

    // Accepts a frame with tx_ready high and checks the four bytes; returns in the cycle after B3.
    task automatic send_frame(input string tag, input logic [24:0] f,
                              input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        frame_in    = f;
        frame_valid = 1'b1;
        tx_ready    = 1'b1;
        tick();
        frame_valid = 1'b0;
        chk({tag, "_txv"}, {7'b0, tx_valid}, 8'h01);
        chk({tag, "_b0"}, tx_data, e0);
        tick();
        chk({tag, "_b1"}, tx_data, e1);
        tick();
        chk({tag, "_b2"}, tx_data, e2);
        tick();
        chk({tag, "_b3"}, tx_data, e3);
        tick();
        chk({tag, "_txv_end"}, {7'b0, tx_valid}, 8'h00);
    endtask

    logic       rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] byte_pat[7] = '{8'h01, 8'h1A, 8'h1A, 8'h1A, 8'hBC, 8'hBC, 8'h5A};

    initial begin
        rst         = 1'b1;
        frame_in    = '0;
        frame_valid = 1'b0;
        tx_ready    = 1'b0;
        rx_data     = '0;
        rx_valid    = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Write at full throughput
        send_frame("wr", {1'b1, 2'b00, 14'h1ABC, 8'h5A}, 8'h01, 8'h1A, 8'hBC, 8'h5A);
        chk("wr_busy_end", {7'b0, frame_busy}, 8'h00);
        chk("wr_rdv", {7'b0, rd_valid_out}, 8'h00);

        // Write under backpressure
        frame_in    = {1'b1, 2'b00, 14'h1ABC, 8'h5A};
        frame_valid = 1'b1;
        tx_ready    = 1'b0;
        tick();
        frame_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tx_ready = rdy_pat[i];
            chk($sformatf("bp_byte%0d", i), tx_data, byte_pat[i]);
            chk($sformatf("bp_txv%0d", i), {7'b0, tx_valid}, 8'h01);
            tick();
        end
        chk("bp_busy_end", {7'b0, frame_busy}, 8'h00);
        chk("bp_txv_end", {7'b0, tx_valid}, 8'h00);

        // Read with a response 10 cycles after WAIT_RX entry; data byte must go out as 00
        send_frame("rd", {1'b0, 2'b00, 14'h0123, 8'hEE}, 8'h00, 8'h01, 8'h23, 8'h00);
        chk("rd_wait_busy", {7'b0, frame_busy}, 8'h01);
        repeat (9) tick();
        chk("rd_wait_rdv", {7'b0, rd_valid_out}, 8'h00);
        rx_data  = 8'hC3;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("rd_rdv", {7'b0, rd_valid_out}, 8'h01);
        chk("rd_data", rd_data_out, 8'hC3);
        chk("rd_tmo", {7'b0, timeout_err}, 8'h00);
        chk("rd_busy_resp", {7'b0, frame_busy}, 8'h01);
        tick();
        chk("rd_rdv_drop", {7'b0, rd_valid_out}, 8'h00);
        chk("rd_busy_end", {7'b0, frame_busy}, 8'h00);
        chk("rd_data_hold", rd_data_out, 8'hC3);

        // Read timeout: 16 cycles after WAIT_RX entry
        send_frame("to", {1'b0, 2'b00, 14'h3FFF, 8'h00}, 8'h00, 8'h3F, 8'hFF, 8'h00);
        repeat (15) tick();
        chk("to_early_rdv", {7'b0, rd_valid_out}, 8'h00);
        chk("to_early_tmo", {7'b0, timeout_err}, 8'h00);
        tick();
        chk("to_rdv", {7'b0, rd_valid_out}, 8'h01);
        chk("to_data", rd_data_out, 8'hFF);
        chk("to_tmo", {7'b0, timeout_err}, 8'h01);
        tick();
        chk("to_tmo_drop", {7'b0, timeout_err}, 8'h00);
        chk("to_rdv_drop", {7'b0, rd_valid_out}, 8'h00);
        chk("to_busy_end", {7'b0, frame_busy}, 8'h00);

        // Response on the terminal cycle beats the timeout
        send_frame("tr", {1'b0, 2'b00, 14'h3FFF, 8'h00}, 8'h00, 8'h3F, 8'hFF, 8'h00);
        repeat (15) tick();
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("tr_rdv", {7'b0, rd_valid_out}, 8'h01);
        chk("tr_data", rd_data_out, 8'h77);
        chk("tr_tmo", {7'b0, timeout_err}, 8'h00);
        tick();

        // Overrun during SEND
        frame_in    = {1'b1, 2'b00, 14'h1ABC, 8'h5A};
        frame_valid = 1'b1;
        tx_ready    = 1'b1;
        tick();
        chk("ov_b0", tx_data, 8'h01);
        chk("ov_pre", {7'b0, overrun_err}, 8'h00);
        frame_in = {1'b1, 2'b00, 14'h0F0F, 8'h99};
        tick();
        frame_valid = 1'b0;
        chk("ov_pulse", {7'b0, overrun_err}, 8'h01);
        chk("ov_b1", tx_data, 8'h1A);
        tick();
        chk("ov_pulse_drop", {7'b0, overrun_err}, 8'h00);
        chk("ov_b2", tx_data, 8'hBC);
        tick();
        chk("ov_b3", tx_data, 8'h5A);
        tick();
        chk("ov_busy_end", {7'b0, frame_busy}, 8'h00);
        tick();
        chk("ov_no_second_txv", {7'b0, tx_valid}, 8'h00);
        chk("ov_no_second_busy", {7'b0, frame_busy}, 8'h00);

        // Reset while waiting for a read response
        send_frame("rs", {1'b0, 2'b00, 14'h0123, 8'h00}, 8'h00, 8'h01, 8'h23, 8'h00);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("rst_mid");
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("rs_ign_rdv", {7'b0, rd_valid_out}, 8'h00);
        chk("rs_ign_data", rd_data_out, 8'h00);
        tick();
        chk("rs_ign_rdv2", {7'b0, rd_valid_out}, 8'h00);
        send_frame("rsw", {1'b1, 2'b00, 14'h2345, 8'hA5}, 8'h01, 8'h23, 8'h45, 8'hA5);
        chk("rsw_busy_end", {7'b0, frame_busy}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bridge_uart_sequencer.md
# bridge_uart_sequencer

Sequences bus-bridge transactions onto a byte-wide UART link. It sits between the slave bus bridge (its 25-bit `uart_register_out` / `valid_out` frame port and its 8-bit `uart_register_in` / `valid_in` response port) and a UART TX/RX pair. Each bridge frame is serialized as 4 bytes under a ready/valid handshake. For read frames, the block waits for one response byte with a timeout and returns it to the bridge, so the bus master is never left hanging.

## Interface
- `ADDR_WIDTH`, 14: bridge address width. Frame width is `ADDR_WIDTH+11`, i.e. 25.
- `DATA_WIDTH`, 8: bridge data width. Fixed at 8 (one UART byte).
- `TIMEOUT_CYCLES`, 4096: cycles to wait for a read response before failing.
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `frame_in`  in  25  bridge frame `{rw, 2'b00, addr[13:0], data[7:0]}`; rw=1 means write
- `frame_valid`  in  1  bridge frame strobe; sampled only in IDLE
- `frame_busy`  out  1  high whenever state is not IDLE
- `rd_data_out`  out  8  read response to bridge `uart_register_in`
- `rd_valid_out`  out  1  one-cycle strobe to bridge `valid_in`
- `tx_data`  out  8  byte to UART TX
- `tx_valid`  out  1  TX byte valid
- `tx_ready`  in  1  UART TX accepts byte
- `rx_data`  in  8  byte from UART RX
- `rx_valid`  in  1  one-cycle RX byte strobe
- `timeout_err`  out  1  one-cycle pulse; read response timed out
- `overrun_err`  out  1  one-cycle pulse; `frame_valid` arrived while busy and was dropped

## Operation
- States: IDLE, SEND, WAIT_RX, RESP.
- **IDLE**
  - On `frame_valid`, latch `frame_in` into a 32-bit shift register `{7'b0, frame_in}`, clear the byte counter and go to SEND.
- **SEND**
  - `tx_data` = upper byte of the shift register; `tx_valid` = 1.
  - Byte order: B0 `{7'b0, rw}`, B1 `{2'b00, addr[13:8]}`, B2 `addr[7:0]`, B3 `data`. Read frames send B3 = 8'h00.
  - A transfer occurs on a cycle with `tx_valid && tx_ready`. On transfer, shift left by 8 and increment the 2-bit counter.
  - After the B3 transfer: a write goes to IDLE; a read clears the timeout counter and goes to WAIT_RX.
- **WAIT_RX**
  - On `rx_valid`, capture `rx_data` into `rd_data_out` and go to RESP.
  - Otherwise, when the timeout counter equals `TIMEOUT_CYCLES-1`, load `rd_data_out` = 8'hFF, pulse `timeout_err` and go to RESP.
  - Otherwise, increment the timeout counter.
- **RESP**
  - `rd_valid_out` = 1 for exactly this one cycle, then go to IDLE.
- `rd_data_out` holds its value until the next capture.
- `rx_valid` outside WAIT_RX is ignored.
- `frame_valid` in any non-IDLE state: pulse `overrun_err` the next cycle. The frame is dropped and the current transaction is unaffected.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES)`. It never wraps: it is cleared on WAIT_RX entry.

## Timing
- **Reset values:** all outputs 0, including `rd_data_out` = 8'h00. State IDLE, counters 0, shift register 0.
- **Reset mid-operation:** `rst` asserted in any state forces IDLE on the next edge. The in-flight frame is abandoned, with no `rd_valid_out` and no error pulse.
- **Frame acceptance:** `frame_valid` high in IDLE at edge N gives SEND, `tx_valid` = 1 and `tx_data` = B0 in cycle N+1.
- **Backpressure:** while `tx_valid && !tx_ready`, `tx_data` stays stable. No byte is ever skipped or duplicated.
- **Write throughput:** with `tx_ready` held at 1, B0–B3 appear in cycles N+1..N+4. IDLE is reached in N+5, and a new frame is accepted in N+5, for 5 cycles per write.
- **Read response:** `rx_valid` at edge M in WAIT_RX gives `rd_valid_out` = 1 with data in cycle M+1. IDLE and `frame_busy` = 0 follow in cycle M+2.
- **Read timeout:** WAIT_RX is entered at cycle W. With no `rx_valid`, `rd_valid_out` = 1 with 8'hFF and `timeout_err` = 1 occur in cycle W+`TIMEOUT_CYCLES`.
- **Simultaneous events:** if `rx_valid` and the terminal count occur together, `rx_valid` wins and no `timeout_err` is raised.
- **Overrun pulse:** `overrun_err` asserts 1 cycle after the offending `frame_valid`, for one cycle.

## Test plan
1. Write frame `{1, 00, 14'h1ABC, 8'h5A}`, `tx_ready` = 1 -> `tx_data` 01, 1A, BC, 5A in cycles N+1..N+4; `frame_busy` low at N+5; no `rd_valid_out`.
2. Same write with `tx_ready` pattern 1,0,0,1,0,1,1 -> bytes 01, 1A, BC, 5A each held stable while stalled; exactly 4 transfers.
3. Read frame addr 14'h0123 -> bytes 00, 01, 23, 00. Then `rx_valid` with 8'hC3 10 cycles after WAIT_RX entry -> `rd_valid_out` one cycle later with `rd_data_out` = C3; `timeout_err` stays 0.
4. `TIMEOUT_CYCLES` = 16, read with no RX byte -> `rd_valid_out` with 8'hFF and `timeout_err` exactly 16 cycles after WAIT_RX entry. Repeat with `rx_valid` = 8'h77 on the terminal cycle -> 8'h77 returned and no error.
5. `frame_valid` pulsed during SEND of a write -> `overrun_err` one-cycle pulse; original byte stream unchanged; no second frame sent.
6. `rst` asserted in WAIT_RX -> next cycle IDLE with all outputs 0. A later `rx_valid` of 8'hAA is ignored, and a fresh write frame is then serialized normally.
